// File: rtl/bind_arbiter.sv
// bind_arbiter: round-robin arbiter that shares one bit-serial XOR binder
// among NUM_REQ requesters. The winner's operands are muxed onto the binder,
// the binder's start/ready handshake is followed to completion, and the
// bound result is handed back with a one-cycle done pulse to that requester.
// Optional watchdog: define BIND_ARB_WDOG_EN to add wdog_err and abort
// operations whose binder handshake stalls.

module bind_arbiter #(
  parameter int DIMENSIONS = 10000,
  parameter int NUM_REQ    = 4
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*DIMENSIONS-1:0]   req_hv1,
  input  logic [NUM_REQ*DIMENSIONS-1:0]   req_hv2,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic [DIMENSIONS-1:0]           hv_result,
  output logic                            bnd_en,
  output logic [DIMENSIONS-1:0]           bnd_hv1,
  output logic [DIMENSIONS-1:0]           bnd_hv2,
  input  logic                            bnd_ready,
  input  logic [DIMENSIONS-1:0]           bnd_hv_out
`ifdef BIND_ARB_WDOG_EN
  ,
  output logic                            wdog_err
`endif
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [IDXW-1:0]       r_owner;
  logic [IDXW-1:0]       r_ptr;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    r_done;
  logic [DIMENSIONS-1:0] r_hvResult;

  logic                  w_found;
  logic [IDXW-1:0]       w_pick;
  logic [NUM_REQ-1:0]    w_pickOneHot;
  logic [NUM_REQ-1:0]    w_ownerOneHot;
  logic [IDXW-1:0]       w_nextPtr;
  logic                  w_wdTrip;

  // Index ptr+off, wrapped back into 0..NUM_REQ-1.
  function automatic logic [IDXW-1:0] wrapAdd(input logic [IDXW-1:0] base, input int off);
    int j;
    j = int'(base) + off;
    if (j >= NUM_REQ) j = j - NUM_REQ;
    return IDXW'(j);
  endfunction

  // Round-robin search: first requester at or after the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req[wrapAdd(r_ptr, i)]) begin
        w_found = 1'b1;
        w_pick  = wrapAdd(r_ptr, i);
      end
    end
  end

  // One-hot views of the winner/owner and the pointer value after this owner.
  always_comb begin
    w_pickOneHot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
    w_ownerOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
    w_nextPtr     = (r_owner == IDXW'(NUM_REQ-1)) ? '0 : r_owner + IDXW'(1);
  end

`ifdef BIND_ARB_WDOG_EN
  localparam int WDW = $clog2(DIMENSIONS + 5);

  logic [WDW-1:0] r_wdCnt;
  logic           r_wdogErr;

  // A stall trips only when the state is not completing normally this cycle.
  always_comb begin
    w_wdTrip = ((r_state == ST_WAIT_BUSY) && bnd_ready && (r_wdCnt == WDW'(4))) ||
               ((r_state == ST_WAIT_DONE) && !bnd_ready && (r_wdCnt == WDW'(DIMENSIONS + 4)));
  end

  // Cycle counter for the current wait state; restarts on every state entry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wdCnt   <= '0;
      r_wdogErr <= 1'b0;
    end else begin
      r_wdogErr <= w_wdTrip;
      if (!w_wdTrip && (((r_state == ST_WAIT_BUSY) && bnd_ready) ||
                        ((r_state == ST_WAIT_DONE) && !bnd_ready)))
        r_wdCnt <= r_wdCnt + WDW'(1);
      else
        r_wdCnt <= '0;
    end
  end

  assign wdog_err = r_wdogErr;
`else
  assign w_wdTrip = 1'b0;
`endif

  // Control FSM: arbitrate, start the binder, follow busy/ready, return result.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_hvResult <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found && bnd_ready) begin
            r_owner <= w_pick;
            r_grant <= w_pickOneHot;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!bnd_ready) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bnd_ready) begin
            r_hvResult <= bnd_hv_out;
            r_done     <= w_ownerOneHot;
            r_grant    <= '0;
            r_ptr      <= w_nextPtr;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_wdTrip) begin
        r_grant <= '0;
        r_ptr   <= w_nextPtr;
        r_state <= ST_IDLE;
      end
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign hv_result = r_hvResult;
  assign bnd_en    = (r_state == ST_START);
  assign bnd_hv1   = req_hv1[int'(r_owner)*DIMENSIONS +: DIMENSIONS];
  assign bnd_hv2   = req_hv2[int'(r_owner)*DIMENSIONS +: DIMENSIONS];

endmodule
